// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding mux encodings,
// divider handshake state, and register-match helpers.
package hazard_pkg;

  // EX operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Divider handshake state
  typedef enum logic {
    DivIdle,
    DivBusy
  } divState_e;

  // A producer hits a consumer only if it writes, is not $0, and indices agree.
  function automatic logic regHit(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && (dst != 5'd0) && (dst == src);
  endfunction

  // Producer hits either of the two ID source registers.
  function automatic logic regHitEither(input logic en, input logic [4:0] dst,
                                        input logic [4:0] srcA, input logic [4:0] srcB);
    return regHit(en, dst, srcA) || regHit(en, dst, srcB);
  endfunction

  // MEM result is newer than WB, so it wins when both match.
  function automatic logic [1:0] fwdSel(input logic hitMem, input logic hitWb);
    if (hitMem) begin
      return FWD_MEM;
    end else if (hitWb) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_div_fsm.sv
// Multi-cycle divider handshake: issues one start pulse per divide and holds
// the EX stage until the divider reports a valid result.
module hazard_div_fsm
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic DivE,
  input  logic DivReady,
  output logic DivStart,
  output logic divStall
);

  divState_e stateQ, stateD;

  // State register with synchronous reset; reset abandons any divide in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= DivIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state: leave IDLE when a divide sits in EX, return on the ready pulse.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      DivIdle: if (DivE)     stateD = DivBusy;
      DivBusy: if (DivReady) stateD = DivIdle;
      default: stateD = DivIdle;
    endcase
  end

  // Outputs: start only from IDLE, so a held divide never restarts. The ready
  // cycle does not stall, letting a back-to-back divide enter EX next cycle.
  always_comb begin
    DivStart = 1'b0;
    divStall = 1'b0;
    unique case (stateQ)
      DivIdle: begin
        DivStart = DivE && !rst;
        divStall = DivE;
      end
      DivBusy: begin
        divStall = !DivReady;
      end
      default: begin
        DivStart = 1'b0;
        divStall = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the 5-stage MIPS pipeline: forwarding
// selects, load-use and branch stalls, divider stall, and a stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReadE,
  input  logic             MemReadM,
  input  logic [1:0]       BranchD,
  input  logic             JumpSrcD,
  input  logic             DivE,
  input  logic             DivReady,
  output logic             DivStart,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt
);

  logic lwStall;
  logic brStall;
  logic divStall;
  logic idNeedsRs;
  logic [CNT_W-1:0] stallCntQ, stallCntD;

  hazard_div_fsm uDivFsm (
    .clk      (clk),
    .rst      (rst),
    .DivE     (DivE),
    .DivReady (DivReady),
    .DivStart (DivStart),
    .divStall (divStall)
  );

  // Forwarding selects; $0 is excluded inside regHit.
  always_comb begin
    ForwardAE = fwdSel(regHit(RegWriteM, WriteRegM, RsE), regHit(RegWriteW, WriteRegW, RsE));
    ForwardBE = fwdSel(regHit(RegWriteM, WriteRegM, RtE), regHit(RegWriteW, WriteRegW, RtE));
    ForwardAD = regHit(RegWriteM, WriteRegM, RsD);
    ForwardBD = regHit(RegWriteM, WriteRegM, RtD);
  end

  // Load-use and branch/jr hazards. Branches resolve in ID, so an ALU result
  // still in EX or a load still in MEM is not yet forwardable to the compare.
  always_comb begin
    idNeedsRs = (BranchD != 2'b00) || JumpSrcD;
    lwStall   = regHitEither(MemReadE, WriteRegE, RsD, RtD);
    brStall   = idNeedsRs &&
                (regHitEither(RegWriteE, WriteRegE, RsD, RtD) ||
                 regHitEither(MemReadM, WriteRegM, RsD, RtD));
  end

  // Pipeline controls. A divide held in EX must not be flushed, so the divider
  // stall masks the bubble insertion.
  always_comb begin
    StallE = divStall;
    StallF = lwStall || brStall || divStall;
    StallD = StallF;
    FlushE = (lwStall || brStall) && !divStall;
  end

  // Stall counter next value: saturate at all-ones rather than wrap.
  always_comb begin
    stallCntD = stallCntQ;
    if (StallF && (stallCntQ != {CNT_W{1'b1}})) begin
      stallCntD = stallCntQ + {{(CNT_W - 1){1'b0}}, 1'b1};
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntQ <= '0;
    end else begin
      stallCntQ <= stallCntD;
    end
  end

  assign StallCnt = stallCntQ;

endmodule
